fwd_hazard_ctrl: RTL and testbench
==================================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Forwarding and hazard controller for the 5-stage pipeline. It drives the 2-bit selects of the two
//  EX-stage 4:1 32-bit operand muxes and the ID-stage branch-comparator forwarding.
//  It tracks destination, regwrite and memread for the EX, MEM and WB stages in its own shadow pipeline.
//  It generates load-use and branch stalls and the IF flush for taken branches.
// PARAMETERS
//  RA_W   5   register address width
//  CNT_W  32  width of the stall performance counter
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  id_valid     in   1      ID stage holds a real instruction
//  id_rs        in   RA_W   ID source register A
//  id_rt        in   RA_W   ID source register B
//  id_uses_rs   in   1      instruction reads rs
//  id_uses_rt   in   1      instruction reads rt
//  id_dst       in   RA_W   ID destination register
//  id_regwrite  in   1      instruction writes the register file
//  id_memread   in   1      instruction is a load
//  id_is_branch in   1      beq/bne; operands are compared in ID
//  br_taken     in   1      ID comparator result
//  stall        out  1      hold PC and IF/ID; equals ~pc_write
//  pc_write     out  1      PC/IF-ID write enable
//  idex_bubble  out  1      insert a nop into ID/EX (equals stall)
//  if_flush     out  1      squash the instruction in IF
//  fwd_a_sel    out  2      EX mux A select
//  fwd_b_sel    out  2      EX mux B select
//  br_fwd_a     out  1      ID comparator A takes the MEM ALU result
//  br_fwd_b     out  1      ID comparator B takes the MEM ALU result
//  stall_count  out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  Shadow pipeline (regs): EX{rs,rt,dst,rw,mr}, MEM{dst,rw,mr}, WB{dst,rw}, advancing every posedge.
//   - EX captures ID fields, except when stall=1 or id_valid=0: then EX is loaded as a bubble (rw=mr=0, dst=0).
//   - MEM<=EX, WB<=MEM each cycle unconditionally.
//  Reset (async): all shadow regs 0 and stall_count=0.
//   - Outputs after reset: stall=0, pc_write=1, fwd sels=00, br_fwd=0, if_flush=0.
//  Effective reads: rs is effective if id_valid&id_uses_rs; rt is effective if id_valid&id_uses_rt.
//   - A read of register 0 never matches anything; nothing forwards from or stalls on $0.
//  Forward selects (combinational, from EX vs MEM/WB shadow):
//   - Encoding: 00 regfile/ID-EX value, 01 WB write data, 10 MEM ALU result, 11 reserved (never driven).
//   - Select 10 when mem_rw & !mem_mr & mem_dst==ex_rs & ex_rs!=0.
//   - Otherwise select 01 when wb_rw & wb_dst==ex_rs & ex_rs!=0.
//   - MEM has priority over WB. Same rules apply to B with ex_rt.
//   - A load in MEM never selects 10; its data arrives via WB.
//  Register file writes in the first half-cycle, so there is no WB->ID forwarding.
//  Stall (combinational); set when any effective source operand X matches:
//   - load-use: ex_mr & ex_dst==X.
//   - branch-ALU: id_is_branch & ex_rw & !ex_mr & ex_dst==X.
//   - branch-load: id_is_branch & mem_mr & mem_dst==X.
//   - Resulting penalties: load->branch 2 stall cycles; ALU->branch 1; load->ALU 1.
//  br_fwd_a/b: id_is_branch & mem_rw & !mem_mr & mem_dst==id_rs/id_rt (!=0).
//  Flush: if_flush = id_valid & id_is_branch & br_taken & ~stall; br_taken is ignored while stalled.
//  stall_count: +1 on every cycle with stall=1; holds at all-ones.
//  Reset mid-stall: outputs return to reset values asynchronously; no pending stall survives.
// TESTING
//  1 add $3 then sub $4,$3,$5 back-to-back
//    -> sub in EX: fwd_a_sel=10, fwd_b_sel=00; no stall.
//  2 add $3; nop; or $6,$5,$3
//    -> or in EX: fwd_b_sel=01.
//    -> with add $3; add $3; or $6,$3,$3: both sels=10 (MEM priority).
//  3 lw $2; add $7,$2,$2
//    -> stall=1 for exactly 1 cycle; EX bubble.
//    -> then fwd_a_sel=fwd_b_sel=01; stall_count=1.
//  4 lw $2; beq $2,$0
//    -> stall 2 cycles; if_flush only in the cycle after the stall when br_taken=1; stall_count=2.
//    -> add $2; beq $2,$1: 1 stall, then br_fwd_a=1.
//  5 writes/reads of $0 never forward or stall.
//    -> reset asserted mid-stall: stall=0 and stall_count=0 immediately, no clock edge needed.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding and hazard controller for a 5-stage pipeline.
// Keeps a shadow copy of the destination, regwrite and memread fields of the EX, MEM
// and WB stages. From that shadow it drives the EX operand forwarding selects and the
// ID branch-comparator forwarding, and it raises the load-use and branch stalls and
// the IF flush for taken branches.
// Ports:
//   clk, reset                      rising-edge clock, asynchronous active-high reset
//   id_valid, id_rs, id_rt          ID instruction is real; its source registers
//   id_uses_rs, id_uses_rt          the instruction actually reads rs / rt
//   id_dst, id_regwrite, id_memread ID destination, register-file write, load
//   id_is_branch, br_taken          beq/bne in ID and the ID comparator result
//   stall, pc_write, idex_bubble    hold PC and IF/ID, with a nop inserted into ID/EX
//   if_flush                        squash the instruction in IF
//   fwd_a_sel, fwd_b_sel            EX operand mux selects (00 regfile, 01 WB, 10 MEM)
//   br_fwd_a, br_fwd_b              ID comparator operand takes the MEM ALU result
//   stall_count                     saturating count of stall cycles
module fwd_hazard_ctrl #(
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [RA_W-1:0]  id_dst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_is_branch,
    input  logic             br_taken,
    output logic             stall,
    output logic             pc_write,
    output logic             idex_bubble,
    output logic             if_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             br_fwd_a,
    output logic             br_fwd_b,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic [RA_W-1:0]  r_ex_rs, r_ex_rt, r_ex_dst;
    logic             r_ex_rw, r_ex_mr;
    logic [RA_W-1:0]  r_mem_dst;
    logic             r_mem_rw, r_mem_mr;
    logic [RA_W-1:0]  r_wb_dst;
    logic             r_wb_rw;
    logic [CNT_W-1:0] r_stall_count;

    logic w_hz_rs, w_hz_rt, w_stall;

    // Stall contribution of one effective source operand; $0 never creates a hazard.
    function automatic logic src_hazard(
        input logic            eff,
        input logic [RA_W-1:0] x,
        input logic            is_br,
        input logic            ex_rw,
        input logic            ex_mr,
        input logic [RA_W-1:0] ex_dst,
        input logic            mem_mr,
        input logic [RA_W-1:0] mem_dst
    );
        logic load_use, br_alu, br_load;
        load_use = ex_mr && (ex_dst == x);
        br_alu   = is_br && ex_rw && !ex_mr && (ex_dst == x);
        br_load  = is_br && mem_mr && (mem_dst == x);
        return eff && (x != '0) && (load_use || br_alu || br_load);
    endfunction

    // EX operand select; a load sitting in MEM has no data yet, so it only forwards from WB.
    function automatic logic [1:0] ex_sel(
        input logic [RA_W-1:0] src,
        input logic            mem_rw,
        input logic            mem_mr,
        input logic [RA_W-1:0] mem_dst,
        input logic            wb_rw,
        input logic [RA_W-1:0] wb_dst
    );
        if (src == '0)                                   return SEL_REG;
        else if (mem_rw && !mem_mr && (mem_dst == src))  return SEL_MEM;
        else if (wb_rw && (wb_dst == src))               return SEL_WB;
        else                                             return SEL_REG;
    endfunction

    // Hazard detection, forwarding and flush decode.
    always_comb begin
        w_hz_rs = src_hazard(id_valid && id_uses_rs, id_rs, id_is_branch,
                             r_ex_rw, r_ex_mr, r_ex_dst, r_mem_mr, r_mem_dst);
        w_hz_rt = src_hazard(id_valid && id_uses_rt, id_rt, id_is_branch,
                             r_ex_rw, r_ex_mr, r_ex_dst, r_mem_mr, r_mem_dst);
        w_stall = w_hz_rs || w_hz_rt;

        stall       = w_stall;
        pc_write    = !w_stall;
        idex_bubble = w_stall;
        if_flush    = id_valid && id_is_branch && br_taken && !w_stall;

        fwd_a_sel = ex_sel(r_ex_rs, r_mem_rw, r_mem_mr, r_mem_dst, r_wb_rw, r_wb_dst);
        fwd_b_sel = ex_sel(r_ex_rt, r_mem_rw, r_mem_mr, r_mem_dst, r_wb_rw, r_wb_dst);

        br_fwd_a = id_is_branch && r_mem_rw && !r_mem_mr && (r_mem_dst == id_rs) && (id_rs != '0);
        br_fwd_b = id_is_branch && r_mem_rw && !r_mem_mr && (r_mem_dst == id_rt) && (id_rt != '0);

        stall_count = r_stall_count;
    end

    // Shadow pipeline; EX takes a bubble when ID is stalled or empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_rs   <= '0;
            r_ex_rt   <= '0;
            r_ex_dst  <= '0;
            r_ex_rw   <= 1'b0;
            r_ex_mr   <= 1'b0;
            r_mem_dst <= '0;
            r_mem_rw  <= 1'b0;
            r_mem_mr  <= 1'b0;
            r_wb_dst  <= '0;
            r_wb_rw   <= 1'b0;
        end else begin
            if (w_stall || !id_valid) begin
                r_ex_rs  <= '0;
                r_ex_rt  <= '0;
                r_ex_dst <= '0;
                r_ex_rw  <= 1'b0;
                r_ex_mr  <= 1'b0;
            end else begin
                r_ex_rs  <= id_rs;
                r_ex_rt  <= id_rt;
                r_ex_dst <= id_dst;
                r_ex_rw  <= id_regwrite;
                r_ex_mr  <= id_memread;
            end
            r_mem_dst <= r_ex_dst;
            r_mem_rw  <= r_ex_rw;
            r_mem_mr  <= r_ex_mr;
            r_wb_dst  <= r_mem_dst;
            r_wb_rw   <= r_mem_rw;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: a vector table applied one ID instruction
// per cycle with expectations queued and compared on the falling edge, plus a
// hand-written reset-during-stall sequence. A 2-bit-counter instance shares the
// stimulus to observe counter saturation.
module tb_fwd_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread, id_is_branch, br_taken;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        stall, pc_write, idex_bubble, if_flush, br_fwd_a, br_fwd_b;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] stall_count;
    logic        s_stall, s_pc_write, s_idex_bubble, s_if_flush, s_br_fwd_a, s_br_fwd_b;
    logic [1:0]  s_fwd_a_sel, s_fwd_b_sel;
    logic [1:0]  s_stall_count;

    int checks = 0;
    int errors = 0;

    fwd_hazard_ctrl #(.RA_W(5), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_is_branch(id_is_branch),
        .br_taken(br_taken), .stall(stall), .pc_write(pc_write), .idex_bubble(idex_bubble),
        .if_flush(if_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .br_fwd_a(br_fwd_a), .br_fwd_b(br_fwd_b), .stall_count(stall_count)
    );

    fwd_hazard_ctrl #(.RA_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_is_branch(id_is_branch),
        .br_taken(br_taken), .stall(s_stall), .pc_write(s_pc_write), .idex_bubble(s_idex_bubble),
        .if_flush(s_if_flush), .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
        .br_fwd_a(s_br_fwd_a), .br_fwd_b(s_br_fwd_b), .stall_count(s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] dst;
        logic       rw, mr, br, tk;
        logic       e_stall, e_flush;
        logic [1:0] e_fa, e_fb;
        logic       e_bfa, e_bfb;
        int         e_cnt;       // -1: counter not checked on this row
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(int v, int rs, int rt, int urs, int urt, int dst, int rw, int mr,
                                int br, int tk, int es, int ef, int fa, int fb, int bfa, int bfb,
                                int cnt);
        vec_t r;
        r.v = 1'(v); r.rs = 5'(rs); r.rt = 5'(rt); r.urs = 1'(urs); r.urt = 1'(urt);
        r.dst = 5'(dst); r.rw = 1'(rw); r.mr = 1'(mr); r.br = 1'(br); r.tk = 1'(tk);
        r.e_stall = 1'(es); r.e_flush = 1'(ef); r.e_fa = 2'(fa); r.e_fb = 2'(fb);
        r.e_bfa = 1'(bfa); r.e_bfb = 1'(bfb); r.e_cnt = cnt;
        return r;
    endfunction

    function automatic vec_t nop(int fa, int fb, int cnt);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fa, fb, 0, 0, cnt);
    endfunction

    task automatic flush3();
        for (int i = 0; i < 3; i++) tbl.push_back(nop(0, 0, -1));
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Drive one ID instruction for a cycle, queue its expectation, compare at the falling edge.
    task automatic apply(input vec_t v, input string name);
        vec_t e;
        logic [9:0] got, want;
        @(posedge clk);
        #1;
        id_valid = v.v; id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
        id_dst = v.dst; id_regwrite = v.rw; id_memread = v.mr; id_is_branch = v.br; br_taken = v.tk;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        got  = {stall, pc_write, idex_bubble, if_flush, fwd_a_sel, fwd_b_sel, br_fwd_a, br_fwd_b};
        want = {e.e_stall, ~e.e_stall, e.e_stall, e.e_flush, e.e_fa, e.e_fb, e.e_bfa, e.e_bfb};
        chk({name, " ctl{stall,pcw,bub,flush,fa,fb,bfa,bfb}"}, 32'(got), 32'(want));
        if (e.e_cnt >= 0) begin
            chk({name, " stall_count"}, stall_count, 32'(e.e_cnt));
            chk({name, " sat_count"}, 32'(s_stall_count), 32'((e.e_cnt > 3) ? 3 : e.e_cnt));
        end
    endtask

    initial begin
        reset = 1'b1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_dst = 0;
        id_regwrite = 0; id_memread = 0; id_is_branch = 0; br_taken = 0;

        // add $3; sub $4,$3,$5 back-to-back
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(nop(2, 0, -1));
        flush3();
        // add $3; nop; or $6,$5,$3
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(nop(0, 0, -1));
        tbl.push_back(mk(1, 5, 3, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(nop(0, 1, -1));
        flush3();
        // add $3; add $3; or $6,$3,$3 : MEM wins over WB
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(mk(1, 3, 3, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(nop(2, 2, -1));
        flush3();
        // lw $2; add $7,$2,$2 : one load-use stall
        tbl.push_back(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 2, 1, 1, 7, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, -1));
        tbl.push_back(mk(1, 2, 2, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(nop(1, 1, 1));
        flush3();
        // lw $2; beq $2,$0 taken : two stalls, flush only afterwards
        tbl.push_back(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(mk(1, 2, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, -1));
        tbl.push_back(mk(1, 2, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, -1));
        tbl.push_back(mk(1, 2, 0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, -1));
        tbl.push_back(nop(0, 0, 3));
        flush3();
        // add $2; beq $2,$1 not taken : one stall then br_fwd_a
        tbl.push_back(mk(1, 3, 4, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(mk(1, 2, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, -1));
        tbl.push_back(mk(1, 2, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, -1));
        tbl.push_back(nop(1, 0, 4));
        flush3();
        // $0 writes and reads never forward or stall
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, -1));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(nop(0, 0, 4));
        flush3();
        // invalid ID and unused operands do not stall; load in MEM never forwards 10
        tbl.push_back(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(mk(0, 2, 2, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(nop(0, 0, -1));
        flush3();
        tbl.push_back(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(mk(1, 2, 3, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(nop(0, 0, -1));
        tbl.push_back(nop(0, 0, 4));
        flush3();

        // Reset state before any clock edge
        #1;
        chk("reset ctl{stall,pcw,bub,flush,fa,fb,bfa,bfb}",
            32'({stall, pc_write, idex_bubble, if_flush, fwd_a_sel, fwd_b_sel, br_fwd_a, br_fwd_b}),
            32'(10'b0100000000));
        chk("reset stall_count", stall_count, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted in the middle of a load-use stall
        apply(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4), "mid_rst lw");
        apply(mk(1, 2, 2, 1, 1, 7, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4), "mid_rst add");
        #1 reset = 1'b1;
        #1;
        chk("mid_rst stall", 32'(stall), 32'd0);
        chk("mid_rst pc_write", 32'(pc_write), 32'd1);
        chk("mid_rst bubble", 32'(idex_bubble), 32'd0);
        chk("mid_rst stall_count", stall_count, 32'd0);
        chk("mid_rst sat_count", 32'(s_stall_count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        apply(mk(1, 2, 2, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst add");
        apply(nop(0, 0, 0), "post_rst nop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
